// File: rtl/arbiter_types.sv
// arbiter_types: FSM state and grant encodings for the memory arbiter.
package arbiter_types;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;
  typedef enum logic {INST, DATA} arb_grant_t;
endpackage

// File: rtl/rv32i_types.sv
// rv32i_types: base RV32I word type shared across the memory subsystem.
package rv32i_types;
  typedef logic [31:0] rv32i_word;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction and data requesters.
module mem_arbiter
  import arbiter_types::*;
  import rv32i_types::*;
#(
  parameter bit DATA_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_byte_enable,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);
  arb_state_t state_q;
  arb_grant_t last_q;
  rv32i_word  addr_q;
  rv32i_word  wdata_q;
  logic [3:0] be_q;
  logic       rd_q;
  logic       wr_q;
  logic       d_req;
  logic       grant_d;
  logic       grant_i;
  always_comb begin
    d_req   = d_read | d_write;
    grant_d = d_req && (!i_read || DATA_PRIO || last_q == INST);
    grant_i = i_read && !grant_d;
  end
  // Latched fields are cleared on completion so mem_* read 0 whenever idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= DATA;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else if (state_q == IDLE) begin
      if (grant_d) begin
        state_q <= BUSY_D;
        last_q  <= DATA;
        addr_q  <= d_address;
        wdata_q <= d_wdata;
        be_q    <= d_byte_enable;
        rd_q    <= !d_write;
        wr_q    <= d_write;
      end else if (grant_i) begin
        state_q <= BUSY_I;
        last_q  <= INST;
        addr_q  <= i_address;
        wdata_q <= '0;
        be_q    <= 4'hF;
        rd_q    <= 1'b1;
        wr_q    <= 1'b0;
      end
    end else if (mem_resp) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end
  end
  assign mem_read        = rd_q;
  assign mem_write       = wr_q;
  assign mem_byte_enable = be_q;
  assign mem_address     = addr_q;
  assign mem_wdata       = wdata_q;
  // A requester that has withdrawn gets no response; the access still completes.
  assign i_resp  = state_q == BUSY_I && mem_resp && i_read;
  assign d_resp  = state_q == BUSY_D && mem_resp && d_req;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DATA_PRIO, default 0, meaning 0 = round-robin between requesters and 1 = data port has fixed priority.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 i_read  input  1  instruction-fetch read request.
REQ-005 i_address  input  32  instruction-fetch address (rv32i_word).
REQ-006 i_rdata  output  32  instruction read data.
REQ-007 i_resp  output  1  instruction transaction complete.
REQ-008 d_read  input  1  data read request.
REQ-009 d_write  input  1  data write request.
REQ-010 d_byte_enable  input  4  data write byte mask.
REQ-011 d_address  input  32  data address.
REQ-012 d_wdata  input  32  data write data.
REQ-013 d_rdata  output  32  data read data.
REQ-014 d_resp  output  1  data transaction complete.
REQ-015 mem_read  output  1  shared memory read strobe.
REQ-016 mem_write  output  1  shared memory write strobe.
REQ-017 mem_byte_enable  output  4  shared memory byte mask.
REQ-018 mem_address  output  32  shared memory address.
REQ-019 mem_wdata  output  32  shared memory write data.
REQ-020 mem_rdata  input  32  shared memory read data.
REQ-021 mem_resp  input  1  shared memory completion, one-cycle pulse.

Function
REQ-022 States SHALL be IDLE, BUSY_I and BUSY_D.
REQ-023 In IDLE, if only one port requests, the FSM SHALL grant it at the next edge.
- Instruction request = i_read.
- Data request = d_read or d_write.
REQ-024 In IDLE with both ports requesting:
- DATA_PRIO=1: grant data.
- DATA_PRIO=0: grant the port not recorded in last_grant.
REQ-025 At grant, the block SHALL latch request fields and update last_grant.
- Latched fields: address, wdata, byte_enable, read/write type.
- Instruction grants latch byte_enable=4'hF, write=0.
REQ-026 mem_* outputs SHALL be driven only from latched registers, never combinationally from requester inputs.
- mem_read/mem_write are high throughout BUSY_x per the latched type.
- All mem_* outputs are 0 in IDLE.
REQ-027 Request-to-mem_read latency SHALL be exactly 1 cycle.
REQ-028 d_read and d_write both high SHALL be treated as a write.
REQ-029 On mem_resp in BUSY_I:
- i_resp=1 and i_rdata=mem_rdata in the same cycle (combinational), only if i_read is still high.
- Otherwise the response is discarded.
- The FSM goes to IDLE at the next edge.
REQ-030 BUSY_D response SHALL follow the same rule, using d_read|d_write and d_resp/d_rdata.
REQ-031 A requester dropping its request mid-transaction SHALL NOT abort the memory access; mem_* stays asserted until mem_resp.
REQ-032 mem_resp in IDLE SHALL be ignored.
REQ-033 i_resp and d_resp SHALL never be high in the same cycle, and each SHALL be high for at most one cycle per grant.
REQ-034 Minimum spacing from one mem_resp to the next mem_read/mem_write SHALL be 1 IDLE cycle; back-to-back grants alternate per REQ-024.
REQ-035 i_rdata and d_rdata SHALL equal mem_rdata whenever their resp is 0; consumers ignore them.

Reset
REQ-036 While rst=0, regardless of clk:
- state=IDLE.
- last_grant=DATA, so the first tie goes to instruction.
- All latched fields=0.
- All mem_* outputs=0; i_resp=d_resp=0.
REQ-037 Reset mid-transaction SHALL abandon the outstanding access immediately; the first grant after rst rises follows REQ-023/024 with no memory of the abandoned access.

Structure
REQ-038 arb_state_t (IDLE/BUSY_I/BUSY_D) and arb_grant_t (INST/DATA) SHALL be defined in a shared package arbiter_types; rv32i_word comes from rv32i_types.
REQ-039 The block SHALL be a single module with no sub-modules.

Verification
REQ-040 i_read=1 with i_address=0x60 and memory responding after 3 cycles -> mem_read high in cycles 1-4 with mem_address=0x60, mem_byte_enable=4'hF, and i_resp one pulse carrying mem_rdata=0x00000013.
REQ-041 i_read and d_write (addr 0x100, wdata 0xDEADBEEF, be 4'b0011) both high from reset, DATA_PRIO=0 -> instruction served first, then one IDLE cycle, then mem_write with the latched data values.
REQ-042 Same stimulus with DATA_PRIO=1 -> data write served first.
REQ-043 d_read dropped two cycles after grant -> mem_read held until mem_resp, d_resp stays 0, FSM returns to IDLE.
REQ-044 rst=0 asserted while in BUSY_D -> all mem_* outputs are 0 in the same cycle, and after release a pending i_read is granted first.
REQ-045 Both ports requesting continuously for 6 transactions with DATA_PRIO=0 -> grant sequence I,D,I,D,I,D and no overlapping resp pulses.
